// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared judge FSM states and counter ceilings for score_keeper
package rhythm_pkg;
  typedef enum logic [1:0] {IDLE, FLYING, JUDGED, OVER} judge_state_t;
  localparam logic [15:0] SCORE_MAX = 16'hFFFF;
  localparam logic [7:0]  COMBO_MAX = 8'd255;
endpackage

// File: rtl/score_sat_add.sv
// score_sat_add: next score = score + points (optionally combo-multiplied), saturating at SCORE_MAX
//   score      in  current score
//   base_pts   in  points per perfect
//   combo      in  combo count before this perfect
//   next_score out saturated sum
//   SCORE_COMBO_BONUS_EN: points scale by 1 + min(combo/10, 3)
module score_sat_add
  import rhythm_pkg::*;
(
  input  logic [15:0] score,
  input  logic [7:0]  base_pts,
  input  logic [7:0]  combo,
  output logic [15:0] next_score
);
  logic [15:0] pts;
  logic [16:0] sum;
`ifdef SCORE_COMBO_BONUS_EN
  logic [2:0] mult;
  assign mult = combo >= 8'd30 ? 3'd4 : combo >= 8'd20 ? 3'd3 : combo >= 8'd10 ? 3'd2 : 3'd1;
  assign pts  = 16'(base_pts) * 16'(mult);
`else
  logic unused_combo;
  assign unused_combo = ^combo;
  assign pts = 16'(base_pts);
`endif
  assign sum        = {1'b0, score} + {1'b0, pts};
  assign next_score = sum[16] ? SCORE_MAX : sum[15:0];
endmodule

// File: rtl/score_keeper.sv
// score_keeper: judges each ball once (perfect/miss) and keeps score, combo, lives
//   frame_clk in  clock; Reset in async active-high reset
//   perfect_f, miss_f, keep_on in  ball-stage flags
//   Score, Combo, MaxCombo, Lives out  registered counters
//   HitP, MissP out one-cycle judgement pulses; GameOver out lives exhausted
//   SCORE_COMBO_BONUS_EN: enables the combo points multiplier in score_sat_add
module score_keeper
  import rhythm_pkg::*;
#(
  parameter int PERFECT_PTS = 10,
  parameter int LIVES       = 5
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        perfect_f,
  input  logic        miss_f,
  input  logic        keep_on,
  output logic [15:0] Score,
  output logic [7:0]  Combo,
  output logic [7:0]  MaxCombo,
  output logic [3:0]  Lives,
  output logic        HitP,
  output logic        MissP,
  output logic        GameOver
);
  judge_state_t state, state_n;
  logic        hit, miss;
  logic [15:0] score_n;
  logic [7:0]  combo_n;
  score_sat_add u_add (
    .score      (Score),
    .base_pts   (8'(PERFECT_PTS)),
    .combo      (Combo),
    .next_score (score_n)
  );
  assign combo_n = Combo == COMBO_MAX ? COMBO_MAX : Combo + 8'd1;
  always_comb begin
    state_n = state;
    hit     = 1'b0;
    miss    = 1'b0;
    case (state)
      IDLE:   state_n = keep_on ? FLYING : IDLE;
      FLYING: begin
        hit     = perfect_f;
        miss    = !perfect_f && (miss_f || !keep_on);
        state_n = hit || miss_f ? JUDGED : !keep_on ? IDLE : FLYING;
      end
      JUDGED: state_n = keep_on ? JUDGED : IDLE;
      OVER:   state_n = OVER;
    endcase
    // the last life lost overrides whatever the ball stage would do next
    if (miss && Lives == 4'd1) state_n = OVER;
  end
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      Score    <= '0;
      Combo    <= '0;
      MaxCombo <= '0;
      Lives    <= 4'(LIVES);
      HitP     <= 1'b0;
      MissP    <= 1'b0;
      GameOver <= 1'b0;
    end else begin
      state <= state_n;
      HitP  <= hit;
      MissP <= miss;
      if (hit) begin
        Score <= score_n;
        Combo <= combo_n;
        if (combo_n > MaxCombo) MaxCombo <= combo_n;
      end
      if (miss) begin
        Combo <= '0;
        Lives <= Lives - 4'd1;
        if (Lives == 4'd1) GameOver <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper (directed balls, queued expectations)
module tb_score_keeper;
  localparam int PP = 10;
  logic        frame_clk = 1'b0;
  logic        Reset, perfect_f, miss_f, keep_on;
  logic [15:0] Score;
  logic [7:0]  Combo, MaxCombo;
  logic [3:0]  Lives;
  logic        HitP, MissP, GameOver;
  score_keeper #(.PERFECT_PTS(PP), .LIVES(5)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .perfect_f (perfect_f),
    .miss_f    (miss_f),
    .keep_on   (keep_on),
    .Score     (Score),
    .Combo     (Combo),
    .MaxCombo  (MaxCombo),
    .Lives     (Lives),
    .HitP      (HitP),
    .MissP     (MissP),
    .GameOver  (GameOver)
  );
  always #5 frame_clk = ~frame_clk;
  typedef struct {
    logic hit;
    int   score;
    int   combo;
    int   maxc;
    int   lives;
    logic over;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int hit_cnt = 0, miss_cnt = 0;
  int m_score, m_combo, m_max, m_lives;
  logic m_over;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int mult(input int c);
`ifdef SCORE_COMBO_BONUS_EN
    return 1 + (c / 10 > 3 ? 3 : c / 10);
`else
    return 1;
`endif
  endfunction
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask
  task automatic model_hit();
    if (!m_over) begin
      m_score = m_score + PP * mult(m_combo);
      if (m_score > 65535) m_score = 65535;
      m_combo = m_combo == 255 ? 255 : m_combo + 1;
      if (m_combo > m_max) m_max = m_combo;
      q.push_back('{hit: 1'b1, score: m_score, combo: m_combo, maxc: m_max, lives: m_lives, over: m_over});
    end
  endtask
  task automatic model_miss();
    if (!m_over) begin
      m_combo = 0;
      m_lives = m_lives - 1;
      m_over  = m_lives == 0;
      q.push_back('{hit: 1'b0, score: m_score, combo: m_combo, maxc: m_max, lives: m_lives, over: m_over});
    end
  endtask
  task automatic apply_reset();
    Reset = 1'b1;
    #1;
    chk("rst_score", Score, 0);
    chk("rst_combo", Combo, 0);
    chk("rst_maxcombo", MaxCombo, 0);
    chk("rst_lives", Lives, 5);
    chk("rst_hitp", HitP, 0);
    chk("rst_missp", MissP, 0);
    chk("rst_gameover", GameOver, 0);
    m_score = 0; m_combo = 0; m_max = 0; m_lives = 5; m_over = 1'b0;
    tick(1);
    Reset = 1'b0;
  endtask
  task automatic ball_perfect();
    keep_on = 1'b1; perfect_f = 1'b1;
    model_hit();
    tick(2);
    keep_on = 1'b0; perfect_f = 1'b0;
    tick(2);
  endtask
  task automatic ball_miss();
    keep_on = 1'b1; miss_f = 1'b1;
    model_miss();
    tick(2);
    keep_on = 1'b0; miss_f = 1'b0;
    tick(2);
  endtask
  task automatic ball_unhit(input int n);
    keep_on = 1'b1;
    model_miss();
    tick(n);
    keep_on = 1'b0;
    tick(2);
  endtask
  always @(negedge frame_clk) begin
    if (!Reset && HitP) hit_cnt++;
    if (!Reset && MissP) miss_cnt++;
    if (!Reset && (HitP || MissP)) begin
      chk("pulse_exclusive", int'(HitP && MissP), 0);
      if (q.size() == 0) begin
        chk("unexpected_pulse", int'({HitP, MissP}), 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("kind_hitp", HitP, e.hit);
        chk("score", Score, e.score);
        chk("combo", Combo, e.combo);
        chk("maxcombo", MaxCombo, e.maxc);
        chk("lives", Lives, e.lives);
        chk("gameover", GameOver, e.over);
      end
    end
  end
  initial begin
    int h0, m0;
    perfect_f = 1'b0; miss_f = 1'b0; keep_on = 1'b0;
    apply_reset();
    h0 = hit_cnt;
    repeat (3) ball_perfect();
    chk("r34_score", Score, 30);
    chk("r34_combo", Combo, 3);
    chk("r34_maxcombo", MaxCombo, 3);
    chk("r34_hit_pulses", hit_cnt - h0, 3);
    m0 = miss_cnt;
    ball_miss();
    chk("r35_combo", Combo, 0);
    chk("r35_maxcombo", MaxCombo, 3);
    chk("r35_lives", Lives, 4);
    chk("r35_miss_pulses", miss_cnt - m0, 1);
    ball_unhit(20);
    chk("r36_lives", Lives, 3);
    chk("r36_score", Score, 30);
    chk("r36_miss_pulses", miss_cnt - m0, 2);
    apply_reset();
    repeat (5) ball_miss();
    chk("r37_lives", Lives, 0);
    chk("r37_gameover", GameOver, 1);
    h0 = hit_cnt;
    ball_perfect();
    chk("r37_over_score", Score, 0);
    chk("r37_over_hits", hit_cnt - h0, 0);
    chk("r37_over_lives", Lives, 0);
    apply_reset();
    repeat (25) ball_perfect();
`ifdef SCORE_COMBO_BONUS_EN
    chk("r38_score", Score, 450);
`else
    chk("r38_score", Score, 250);
`endif
    chk("r38_combo", Combo, 25);
    chk("r38_maxcombo", MaxCombo, 25);
    apply_reset();
    repeat (2) ball_perfect();
    chk("r39_pre_score", Score, 20);
    keep_on = 1'b1;
    tick(3);
    apply_reset();
    m0 = miss_cnt;
    tick(1);
    keep_on = 1'b0;
    model_miss();
    tick(3);
    chk("r39_one_judgement", miss_cnt - m0, 1);
    chk("r39_lives", Lives, 4);
    chk("r39_score", Score, 0);
    tick(3);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
